mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port 512x16 RAM between the CPU instruction-fetch stage and the memory (load/store) stage.
- Grants at most one access per cycle.
- Tracks in-flight reads through the RAM's fixed read latency and routes each returned word to the requester that issued it.
- Generates the fetch-stall signal for the IF/ID pipeline register. It sits between the cpu core and the RAM module.

Parameters:
RD_LAT, 1, RAM read latency in cycles from command cycle to mem_rdata valid (legal 1..4)
STARVE_MAX, 3, consecutive denied IF cycles before IF gets priority; 0 = data always wins
AW, 9, address width
DW, 16, data width

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
if_req  in  1  fetch read request; held with if_addr stable until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_valid  out  1  fetch data valid this cycle
if_rdata  out  DW  fetch data; 0 when if_valid low
d_req  in  1  data request; held with d_write/d_addr/d_wdata stable until d_gnt
d_write  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_gnt  out  1  data request accepted this cycle
d_valid  out  1  load data valid this cycle (never pulses for stores)
d_rdata  out  DW  load data; 0 when d_valid low
halt  in  1  when high, no new IF grants
stall  out  1  if_req & ~if_gnt
mem_cmd  out  2  00 none, 01 read, 10 write (11 never driven)
mem_addr  out  AW  RAM address; 0 when mem_cmd = 00
mem_wdata  out  DW  RAM write data; 0 unless mem_cmd = 10
mem_rdata  in  DW  RAM read data, valid RD_LAT cycles after a read command

Behaviour:
- Grant logic is combinational on the current cycle's requests and state.
  - mem_cmd, mem_addr and mem_wdata follow the winner in the same cycle.
  - The RAM samples them on the next posedge.
- Priority:
  - Only one requester: it wins, unless it is IF and halt = 1.
  - Both request: data wins, unless starve_cnt == STARVE_MAX and STARVE_MAX != 0; then IF wins.
- starve_cnt (width covers STARVE_MAX):
  - Increments each cycle with if_req & ~if_gnt & ~halt, saturating at STARVE_MAX.
  - Clears on if_gnt, on ~if_req, or while halt = 1.
- Tag pipeline: RD_LAT-deep shift register of {valid, owner}.
  - A granted read pushes {1, IF/D}; a cycle with no read grant pushes {0, x}.
  - At the tail, valid routes mem_rdata to the owner's rdata and raises that owner's valid for exactly that cycle.
- Latency:
  - Read granted in cycle t -> valid/rdata in cycle t+RD_LAT.
  - Store granted in cycle t completes at the posedge ending cycle t. No response pulse.
- Back-to-back grants are allowed every cycle.
  - Up to RD_LAT reads in flight; returns stay in grant order.
  - A return and a new grant in the same cycle are independent.
- Store then load to the same address in consecutive cycles: no forwarding; the result follows RAM write-then-read semantics.
- halt = 1:
  - IF denied, so stall = if_req.
  - Data requests and in-flight IF returns still complete.
- Reset (any cycle, including with reads in flight):
  - While reset is high: if_gnt = d_gnt = 0, mem_cmd = 00, stall = if_req.
  - At the posedge with reset high: tag pipeline and starve_cnt clear. In-flight reads are dropped (no valid pulse, not even at their scheduled cycle).
- Outputs after reset with no requests:
  - all valid/gnt = 0, rdata = 0, mem_cmd = 00, mem_addr = 0, mem_wdata = 0, stall = 0.
- Requesters must not drop req before gnt. If they do, the request is simply withdrawn and no state is corrupted.

Test Plan:
- RD_LAT=1: IF only, if_req=1, if_addr=0x005, RAM[5]=0xA1B2 -> if_gnt=1 and mem_cmd=01, mem_addr=0x005 in cycle t; if_valid=1, if_rdata=0xA1B2 in t+1; stall=0.
- Both request every cycle, STARVE_MAX=3, d_write=0 -> d_gnt in cycles 0,1,2, IF granted in cycle 3; stall=1 in cycles 0-2, 0 in cycle 3; pattern repeats; returns are correctly tagged.
- Store d_addr=0x010, d_wdata=0x1234, then load 0x010 next cycle -> mem_cmd=10 then 01; d_valid only once, with d_rdata=0x1234; no valid pulse for the store.
- RD_LAT=3, alternate IF/D reads to addresses 1,2,3,4 on consecutive cycles -> valids alternate IF/D starting at cycle 3, data matches RAM[1..4] in order.
- halt=1 with if_req=1 and d_req=1 (load 0x020) -> if_gnt=0 and stall=1 throughout, d_gnt=1; IF read already in flight still returns.
- Reset asserted one cycle after an IF read grant (RD_LAT=2) -> no if_valid at t+2; all outputs 0; starve_cnt=0; first grant after reset follows fresh priority.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port RAM between the instruction-fetch (IF) stage and
//   the load/store (D) stage.  At most one RAM command is issued per cycle.
//   Reads are tracked through the RAM's fixed read latency so that each
//   returned word goes back to the stage that asked for it.  Also produces
//   the fetch stall for the IF/ID pipeline register.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   if_req/if_addr        fetch read request (held until if_gnt)
//   if_gnt                fetch accepted this cycle
//   if_valid/if_rdata     fetch read data (rdata forced to 0 when not valid)
//   d_req/d_write/d_addr/d_wdata
//                         load/store request (held until d_gnt)
//   d_gnt                 data request accepted this cycle
//   d_valid/d_rdata       load data (stores never return anything)
//   halt                  blocks new fetch grants
//   stall                 fetch requested but not granted
//   mem_cmd/mem_addr/mem_wdata
//                         RAM command: 00 none, 01 read, 10 write
//   mem_rdata             RAM read data, RD_LAT cycles after a read command
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 3,
    parameter int AW         = 9,
    parameter int DW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    input  logic          halt,
    output logic          stall,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    logic [SW-1:0]     starve_cnt;
    // Stage k holds the tag of the read granted k cycles ago; the tail
    // (stage RD_LAT) lines up with mem_rdata.  own_pipe: 1 = IF, 0 = D.
    logic [RD_LAT:1]   vld_pipe;
    logic [RD_LAT:1]   own_pipe;

    logic if_ok, d_ok, if_prio, rd_push, ret_vld;

    always_comb begin
        // Reset masks both requesters so nothing reaches the RAM.
        if_ok   = if_req & ~halt & ~reset;
        d_ok    = d_req & ~reset;
        // Fetch only overrides data once it has been starved long enough.
        if_prio = (STARVE_MAX != 0) && (starve_cnt == SW'(STARVE_MAX));
        if_gnt  = if_ok & (~d_ok | if_prio);
        d_gnt   = d_ok & ~if_gnt;
        stall   = if_req & ~if_gnt;
        rd_push = if_gnt | (d_gnt & ~d_write);

        mem_cmd   = CMD_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_cmd  = CMD_READ;
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
            if (d_write) begin
                mem_cmd   = CMD_WRITE;
                mem_wdata = d_wdata;
            end else begin
                mem_cmd = CMD_READ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            vld_pipe   <= '0;
            own_pipe   <= '0;
        end else begin
            if (if_gnt || !if_req || halt)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;

            vld_pipe[1] <= rd_push;
            own_pipe[1] <= if_gnt;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                own_pipe[i] <= own_pipe[i-1];
            end
        end
    end

    // A read whose return lands in a reset cycle is dropped with the rest of
    // the in-flight reads, so the tail is masked while reset is high.
    always_comb begin
        ret_vld  = vld_pipe[RD_LAT] & ~reset;
        if_valid = ret_vld & own_pipe[RD_LAT];
        d_valid  = ret_vld & ~own_pipe[RD_LAT];
        if_rdata = if_valid ? mem_rdata : '0;
        d_rdata  = d_valid  ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Three arbiters (RD_LAT = 1, 2, 3, STARVE_MAX = 3) share one stimulus
//   stream, each with its own RAM read-latency pipe over a common RAM
//   array.  Directed steps check grants and the RAM command combinationally;
//   every expected read return is queued per instance and a separate monitor
//   pops and compares owner, data and arrival cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_write, halt;
    logic [8:0]  if_addr, d_addr;
    logic [15:0] d_wdata;

    logic [NI-1:0] ifg, dg, ifv, dv, stl;
    logic [1:0]    cmd   [NI];
    logic [8:0]    maddr [NI];
    logic [15:0]   mwd   [NI];
    logic [15:0]   ifd   [NI];
    logic [15:0]   dd    [NI];
    logic [15:0]   mrd   [NI];

    logic [15:0] ram [0:511];

    typedef struct {
        logic        own;   // 1 = IF
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sbq [NI][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM write port follows instance 0; all instances see identical stimulus.
    always @(posedge clk) if (cmd[0] == 2'b10) ram[maddr[0]] <= mwd[0];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [15:0] rp [0:NI-1];

        mem_port_arbiter #(.RD_LAT(g + 1), .STARVE_MAX(3), .AW(9), .DW(16)) u_dut (
            .clk(clk), .reset(reset),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(ifg[g]),
            .if_valid(ifv[g]), .if_rdata(ifd[g]),
            .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_gnt(dg[g]), .d_valid(dv[g]), .d_rdata(dd[g]),
            .halt(halt), .stall(stl[g]),
            .mem_cmd(cmd[g]), .mem_addr(maddr[g]), .mem_wdata(mwd[g]),
            .mem_rdata(mrd[g])
        );

        always @(posedge clk) begin
            rp[0] <= (cmd[g] == 2'b01) ? ram[maddr[g]] : 16'hDEAD;
            for (int k = 1; k < NI; k++) rp[k] <= rp[k-1];
        end
        assign mrd[g] = rp[g];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops on every return, flags unexpected or overdue ones.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int g = 0; g < NI; g++) begin
                if (ifv[g] && dv[g]) chk($sformatf("L%0d both_valid", g + 1), 1, 0);
                if (ifv[g] || dv[g]) begin
                    if (sbq[g].size() == 0) begin
                        chk($sformatf("L%0d unexpected_return", g + 1), {ifv[g], dv[g]}, 0);
                    end else begin
                        exp_t e;
                        e = sbq[g].pop_front();
                        chk($sformatf("L%0d ret_cycle", g + 1), cyc, e.cyc);
                        chk($sformatf("L%0d ret_owner_if", g + 1), ifv[g], e.own);
                        chk($sformatf("L%0d ret_data", g + 1), e.own ? ifd[g] : dd[g], e.data);
                    end
                end else if (sbq[g].size() > 0 && sbq[g][0].cyc < cyc) begin
                    exp_t e;
                    e = sbq[g].pop_front();
                    chk($sformatf("L%0d missing_return", g + 1), cyc, e.cyc);
                end
                if (!ifv[g]) chk($sformatf("L%0d if_rdata_idle", g + 1), ifd[g], 0);
                if (!dv[g])  chk($sformatf("L%0d d_rdata_idle", g + 1), dd[g], 0);
            end
        end
    end

    // One cycle: drive at posedge+1, check at negedge, queue any expected read.
    task automatic step(input string nm,
                        input logic ifr, input logic [8:0] ia,
                        input logic dr, input logic dw, input logic [8:0] da,
                        input logic [15:0] dwd, input logic h, input logic rst,
                        input logic e_ifg, input logic e_dg, input logic [1:0] e_cmd,
                        input logic [8:0] e_addr, input logic [15:0] e_wd,
                        input logic e_stall, input logic [15:0] e_rd);
        if_req = ifr; if_addr = ia;
        d_req = dr; d_write = dw; d_addr = da; d_wdata = dwd;
        halt = h; reset = rst;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("%s L%0d if_gnt", nm, g + 1), ifg[g], e_ifg);
            chk($sformatf("%s L%0d d_gnt", nm, g + 1), dg[g], e_dg);
            chk($sformatf("%s L%0d stall", nm, g + 1), stl[g], e_stall);
            chk($sformatf("%s L%0d mem_cmd", nm, g + 1), cmd[g], e_cmd);
            chk($sformatf("%s L%0d mem_addr", nm, g + 1), maddr[g], e_addr);
            chk($sformatf("%s L%0d mem_wdata", nm, g + 1), mwd[g], e_wd);
            // Reads still in flight at a reset cycle are never returned.
            if (rst)
                while (sbq[g].size() > 0 && sbq[g][sbq[g].size()-1].cyc >= cyc)
                    void'(sbq[g].pop_back());
            if (e_cmd == 2'b01) begin
                exp_t e;
                e.own = e_ifg; e.data = e_rd; e.cyc = cyc + g + 1;
                sbq[g].push_back(e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] <= 16'h0000;
        ram[1] <= 16'h1111; ram[2] <= 16'h2222; ram[3] <= 16'h3333; ram[4] <= 16'h4444;
        ram[5] <= 16'hA1B2; ram[6] <= 16'h0606; ram[9'h20] <= 16'h2020;
        for (int i = 0; i < 8; i++) ram[9'h30 + i] <= 16'h3000 + 16'(i);
        ram[9'h40] <= 16'h4000; ram[9'h41] <= 16'h4001;
        reset = 1; if_req = 0; if_addr = 0; d_req = 0; d_write = 0;
        d_addr = 0; d_wdata = 0; halt = 0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // reset holds off grants; stall mirrors if_req
        step("rst_busy", 1, 5, 1, 0, 9'h20, 0, 0, 1,  0, 0, 2'b00, 0, 0, 1, 0);
        step("rst_quiet", 0, 0, 0, 0, 0, 0, 0, 1,     0, 0, 2'b00, 0, 0, 0, 0);
        idle(1);

        // single fetch
        step("if_only", 1, 5, 0, 0, 0, 0, 0, 0,       1, 0, 2'b01, 5, 0, 0, 16'hA1B2);
        idle(1);

        // both requesting: data x3 then starved fetch wins, twice
        step("stv0", 1, 9'h40, 1, 0, 9'h30, 0, 0, 0,  0, 1, 2'b01, 9'h30, 0, 1, 16'h3000);
        step("stv1", 1, 9'h40, 1, 0, 9'h31, 0, 0, 0,  0, 1, 2'b01, 9'h31, 0, 1, 16'h3001);
        step("stv2", 1, 9'h40, 1, 0, 9'h32, 0, 0, 0,  0, 1, 2'b01, 9'h32, 0, 1, 16'h3002);
        step("stv3", 1, 9'h40, 1, 0, 9'h33, 0, 0, 0,  1, 0, 2'b01, 9'h40, 0, 0, 16'h4000);
        step("stv4", 1, 9'h41, 1, 0, 9'h33, 0, 0, 0,  0, 1, 2'b01, 9'h33, 0, 1, 16'h3003);
        step("stv5", 1, 9'h41, 1, 0, 9'h34, 0, 0, 0,  0, 1, 2'b01, 9'h34, 0, 1, 16'h3004);
        step("stv6", 1, 9'h41, 1, 0, 9'h35, 0, 0, 0,  0, 1, 2'b01, 9'h35, 0, 1, 16'h3005);
        step("stv7", 1, 9'h41, 1, 0, 9'h36, 0, 0, 0,  1, 0, 2'b01, 9'h41, 0, 0, 16'h4001);
        idle(1);

        // store then load same address: RAM write-then-read
        step("store", 0, 0, 1, 1, 9'h10, 16'h1234, 0, 0, 0, 1, 2'b10, 9'h10, 16'h1234, 0, 0);
        step("load", 0, 0, 1, 0, 9'h10, 0, 0, 0,      0, 1, 2'b01, 9'h10, 0, 0, 16'h1234);
        idle(1);

        // alternating IF/D reads, back to back
        step("alt_if1", 1, 1, 0, 0, 0, 0, 0, 0,       1, 0, 2'b01, 1, 0, 0, 16'h1111);
        step("alt_d2", 0, 0, 1, 0, 2, 0, 0, 0,        0, 1, 2'b01, 2, 0, 0, 16'h2222);
        step("alt_if3", 1, 3, 0, 0, 0, 0, 0, 0,       1, 0, 2'b01, 3, 0, 0, 16'h3333);
        step("alt_d4", 0, 0, 1, 0, 4, 0, 0, 0,        0, 1, 2'b01, 4, 0, 0, 16'h4444);
        idle(3);

        // halt: fetch blocked, data proceeds, in-flight fetch still returns
        step("pre_halt", 1, 5, 0, 0, 0, 0, 0, 0,      1, 0, 2'b01, 5, 0, 0, 16'hA1B2);
        step("halt_d", 1, 6, 1, 0, 9'h20, 0, 1, 0,    0, 1, 2'b01, 9'h20, 0, 1, 16'h2020);
        step("halt_if", 1, 6, 0, 0, 0, 0, 1, 0,       0, 0, 2'b00, 0, 0, 1, 0);
        step("halt_d2", 1, 6, 1, 0, 9'h20, 0, 1, 0,   0, 1, 2'b01, 9'h20, 0, 1, 16'h2020);
        step("unhalt", 1, 6, 0, 0, 0, 0, 0, 0,        1, 0, 2'b01, 6, 0, 0, 16'h0606);
        idle(3);

        // reset right after a fetch grant drops the return
        step("rs_if", 1, 1, 0, 0, 0, 0, 0, 0,         1, 0, 2'b01, 1, 0, 0, 16'h1111);
        step("rs_rst", 1, 2, 1, 0, 2, 0, 0, 1,        0, 0, 2'b00, 0, 0, 1, 0);
        idle(1);

        // starve count cleared by reset: fresh 3 data wins before fetch
        step("rs_d0", 1, 3, 1, 0, 9'h30, 0, 0, 0,     0, 1, 2'b01, 9'h30, 0, 1, 16'h3000);
        step("rs_d1", 1, 3, 1, 0, 9'h31, 0, 0, 0,     0, 1, 2'b01, 9'h31, 0, 1, 16'h3001);
        step("rs_rst2", 1, 3, 1, 0, 9'h32, 0, 0, 1,   0, 0, 2'b00, 0, 0, 1, 0);
        step("rs_d2", 1, 3, 1, 0, 9'h32, 0, 0, 0,     0, 1, 2'b01, 9'h32, 0, 1, 16'h3002);
        step("rs_d3", 1, 3, 1, 0, 9'h33, 0, 0, 0,     0, 1, 2'b01, 9'h33, 0, 1, 16'h3003);
        step("rs_d4", 1, 3, 1, 0, 9'h34, 0, 0, 0,     0, 1, 2'b01, 9'h34, 0, 1, 16'h3004);
        step("rs_if3", 1, 3, 1, 0, 9'h35, 0, 0, 0,    1, 0, 2'b01, 3, 0, 0, 16'h3333);
        idle(6);

        for (int g = 0; g < NI; g++)
            chk($sformatf("L%0d sb_drained", g + 1), sbq[g].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
